// File: rtl/bkm68x_bus_slave.sv
// bkm68x_bus_slave: monitor slot bus slave for the BKM-68X card edge.
// Brings the asynchronous multiplexed address/data bus into the clk_20mhz
// domain, decodes address/write/read events against a small register file
// and drives the video-path select lines and a maskable interrupt.
`timescale 1ns/1ps

module bkm68x_bus_slave #(
    parameter int         NUM_REGS         = 16,
    parameter int         NUM_IRQ          = 4,
    parameter int         SYNC_STAGES      = 2,
    parameter logic [7:0] CARD_ID          = 8'h68,
    parameter bit         AUTO_INC_DEFAULT = 1'b1
) (
    input  logic               clk_20mhz,
    input  logic               reset,
    input  logic               slot_x,
    input  logic               clk_rw,
    input  logic               ax_d,
    input  logic               r_wx,
    input  logic [7:0]         data_in,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic [7:0]         data_out,
    output logic               data_oe_x,
    output logic               int_x,
    output logic               int_oe_x,
    output logic               hd_sd_x,
    output logic               rgb_comp_x,
    output logic               int_ext_x,
    output logic               video_oe_x
);

    localparam int              ADDR_W     = $clog2(NUM_REGS);
    localparam logic [7:0]      CTRL_RESET = 8'h07 | (8'(AUTO_INC_DEFAULT) << 3);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    // Synchroniser chains; index 0 is nearest the pin, the top index is the
    // synchronised copy used by the decode logic.
    logic [SYNC_STAGES-1:0] slot_sync_q, slot_sync_d;
    logic [SYNC_STAGES-1:0] rw_sync_q, rw_sync_d;
    logic [SYNC_STAGES-1:0] ax_sync_q, ax_sync_d;
    logic [SYNC_STAGES-1:0] rwx_sync_q, rwx_sync_d;
    logic [7:0]             data_sync_q [SYNC_STAGES];
    logic [7:0]             data_sync_d [SYNC_STAGES];
    logic                   rw_prev_q, rw_prev_d;

    logic       slot_s, rw_s, ax_s, rwx_s;
    logic [7:0] data_s;

    // Register file state.
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               oor_q, oor_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [NUM_IRQ-1:0] status_q, status_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] w1c;
    logic [7:0]         mem_q [NUM_REGS];
    logic [7:0]         mem_d [NUM_REGS];

    // Registered outputs.
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_x_q, data_oe_x_d;
    logic       int_x_q, int_x_d;

    logic bus_event, addr_event, wr_event, rd_event;
    logic [7:0] rd_byte;

    assign slot_s = slot_sync_q[SYNC_STAGES-1];
    assign rw_s   = rw_sync_q[SYNC_STAGES-1];
    assign ax_s   = ax_sync_q[SYNC_STAGES-1];
    assign rwx_s  = rwx_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Shift every bus pin one stage further along its synchroniser chain.
    always_comb begin
        slot_sync_d = {slot_sync_q[SYNC_STAGES-2:0], slot_x};
        rw_sync_d   = {rw_sync_q[SYNC_STAGES-2:0], clk_rw};
        ax_sync_d   = {ax_sync_q[SYNC_STAGES-2:0], ax_d};
        rwx_sync_d  = {rwx_sync_q[SYNC_STAGES-2:0], r_wx};
        data_sync_d[0] = data_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_d[i] = data_sync_q[i-1];
        end
        rw_prev_d = rw_s;
    end

    // A bus event is a synchronised strobe rising edge while the slot is selected.
    always_comb begin
        bus_event  = rw_s & ~rw_prev_q & ~slot_s;
        addr_event = bus_event & ax_s;
        wr_event   = bus_event & ~ax_s & ~rwx_s;
        rd_event   = bus_event & ~ax_s & rwx_s;
    end

    // Next-state for pointer, registers and interrupt status from decoded events.
    always_comb begin
        ptr_d  = ptr_q;
        oor_d  = oor_q;
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        mem_d  = mem_q;
        w1c    = '0;

        if (addr_event) begin
            ptr_d = data_s[ADDR_W-1:0];
            oor_d = ({24'd0, data_s} >= 32'(NUM_REGS));
        end

        // Register 0 is the read-only card ID, so writes to it are dropped.
        if (wr_event && !oor_q && (ptr_q != '0)) begin
            case (ptr_q)
                ADDR_W'(1): ctrl_d = data_s;
                ADDR_W'(2): w1c    = data_s[NUM_IRQ-1:0];
                ADDR_W'(3): mask_d = data_s[NUM_IRQ-1:0];
                default:    mem_d[ptr_q] = data_s;
            endcase
        end

        // Auto-increment follows the ctrl value in force before this event.
        if ((wr_event || rd_event) && ctrl_q[3]) begin
            ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + ADDR_W'(1);
        end

        // A new source pulse beats a clear of the same bit.
        status_d = (status_q & ~w1c) | irq_src;
    end

    // Read mux and registered bus-facing outputs.
    always_comb begin
        case (ptr_q)
            ADDR_W'(0): rd_byte = CARD_ID;
            ADDR_W'(1): rd_byte = ctrl_q;
            ADDR_W'(2): rd_byte = 8'(status_q);
            ADDR_W'(3): rd_byte = 8'(mask_q);
            default:    rd_byte = mem_q[ptr_q];
        endcase
        data_out_d  = oor_q ? 8'hFF : rd_byte;
        data_oe_x_d = ~(~slot_s & rwx_s & ~ax_s);
        int_x_d     = ~|(status_q & mask_q);
    end

    // All state, with the synchronisers resetting to an idle, deselected bus.
    always_ff @(posedge clk_20mhz) begin
        if (reset) begin
            slot_sync_q <= '1;
            rw_sync_q   <= '1;
            ax_sync_q   <= '0;
            rwx_sync_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= '0;
            end
            rw_prev_q   <= 1'b1;
            ptr_q       <= '0;
            oor_q       <= 1'b0;
            ctrl_q      <= CTRL_RESET;
            status_q    <= '0;
            mask_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q  <= 8'hFF;
            data_oe_x_q <= 1'b1;
            int_x_q     <= 1'b1;
        end else begin
            slot_sync_q <= slot_sync_d;
            rw_sync_q   <= rw_sync_d;
            ax_sync_q   <= ax_sync_d;
            rwx_sync_q  <= rwx_sync_d;
            data_sync_q <= data_sync_d;
            rw_prev_q   <= rw_prev_d;
            ptr_q       <= ptr_d;
            oor_q       <= oor_d;
            ctrl_q      <= ctrl_d;
            status_q    <= status_d;
            mask_q      <= mask_d;
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            data_oe_x_q <= data_oe_x_d;
            int_x_q     <= int_x_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_oe_x  = data_oe_x_q;
    assign int_x      = int_x_q;
    assign int_oe_x   = int_x_q;
    assign hd_sd_x    = ctrl_q[0];
    assign rgb_comp_x = ctrl_q[1];
    assign int_ext_x  = ctrl_q[2];
    assign video_oe_x = ~ctrl_q[7];

endmodule

// File: doc/bkm68x_bus_slave.md
# bkm68x_bus_slave

Parametrised slave for the BKM-68X monitor slot bus: synchronises the monitor's multiplexed 8-bit address/data bus into the `clk_20mhz` domain and decodes address and data phases. It serves a register file of `NUM_REGS` bytes with optional pointer auto-increment, and raises a maskable interrupt from `NUM_IRQ` fabric sources. It sits directly behind the card-edge pins and drives the video-path select lines (`hd_sd_x`, `rgb_comp_x`, `int_ext_x`, `video_oe_x`) from its control register. It supersedes the fixed single-function monitor interface.

## Interface
- `NUM_REGS`, 16: register count, 5..256; pointer width `ADDR_W = clog2(NUM_REGS)`.
- `NUM_IRQ`, 4: interrupt sources, 1..8.
- `SYNC_STAGES`, 2: synchroniser depth, at least 2.
- `CARD_ID`, 8'h68: value returned by register 0.
- `AUTO_INC_DEFAULT`, 1: reset value of ctrl bit 3.

Ports:
- `clk_20mhz` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `slot_x` in 1: slot select, active low, asynchronous.
- `clk_rw` in 1: bus strobe, asynchronous.
- `ax_d` in 1: phase select, 1 = address phase, 0 = data phase.
- `r_wx` in 1: 1 = read, 0 = write.
- `data_in` in 8: bus data from the monitor.
- `irq_src` in NUM_IRQ: fabric interrupt pulses, one-cycle, `clk_20mhz` domain.
- `data_out` out 8: read data.
- `data_oe_x` out 1: read-data output enable, active low.
- `int_x` out 1: interrupt, active low.
- `int_oe_x` out 1: interrupt driver enable, active low.
- `hd_sd_x`, `rgb_comp_x`, `int_ext_x` out 1 each: ctrl bits 0, 1, 2.
- `video_oe_x` out 1: inverse of ctrl bit 7.

## Operation
- Synchronisation
  - `slot_x`, `clk_rw`, `ax_d`, `r_wx` and `data_in` each pass through `SYNC_STAGES` flops.
  - A rising edge of synchronised `clk_rw` while synchronised `slot_x` = 0 produces one bus event, decoded from the synchronised `ax_d` and `r_wx`.
- Address event (`ax_d` = 1): `ptr <= data_in[ADDR_W-1:0]`. Upper bits of `data_in` are stored in an `oor` flag, set if `data_in >= NUM_REGS`.
- Write event (`ax_d` = 0, `r_wx` = 0): write `data_in` to `reg[ptr]` unless `oor` is set or `ptr` = 0.
- Read event (`ax_d` = 0, `r_wx` = 1): completes a read, no state change other than auto-increment.
- Auto-increment: after any data event, if ctrl[3] = 1, `ptr <= (ptr == NUM_REGS-1) ? 0 : ptr+1`. `oor` is not cleared by auto-increment.
- Register map
  - 0: ID, read-only, returns `CARD_ID`.
  - 1: ctrl.
  - 2: IRQ status; write-1-to-clear.
  - 3: IRQ mask; bits ≥ `NUM_IRQ` read 0.
  - 4..`NUM_REGS`-1: general read/write.
- `data_out` is registered every cycle: `oor ? 8'hFF : reg[ptr]`.
- `data_oe_x` = 0 iff synchronised `slot_x` = 0, `r_wx` = 1 and `ax_d` = 0. It is registered.
- IRQ status
  - `status[i] <= (status[i] & ~w1c[i]) | irq_src[i]`.
  - If a source pulse and a W1C of the same bit occur in the same cycle, the set wins.
- Interrupt outputs: `int_x` = ~|(status & mask), registered; `int_oe_x` = `int_x`.

## Timing
- Reset values
  - `data_out` = FF, `data_oe_x` = 1, `int_x` = 1, `int_oe_x` = 1.
  - ctrl = 8'h07 | (`AUTO_INC_DEFAULT` << 3), so `hd_sd_x` = `rgb_comp_x` = `int_ext_x` = 1 and `video_oe_x` = 1.
  - `ptr` = 0, `oor` = 0, status = 0, mask = 0, general registers = 0.
  - All synchroniser flops reset to the idle bus state: `slot_x` = 1, `clk_rw` = 1, so no spurious edge is seen after reset.
- Event latency: the register update occurs `SYNC_STAGES`+1 cycles after the `clk_rw` pin rises. Updated `data_out` follows one cycle later.
- Bus constraints
  - `clk_rw` high and low times ≥ (`SYNC_STAGES`+2) × 50 ns.
  - `data_in`, `ax_d`, `r_wx` and `slot_x` must be stable from one period before the `clk_rw` rise until one period after it.
- `int_x` asserts 2 cycles after an `irq_src` pulse on an unmasked bit. It deasserts 2 cycles after the W1C event.
- Reset mid-bus-cycle: all state returns to reset values. The next edge counted is the first rising edge of synchronised `clk_rw` after reset is released.
- `slot_x` rising during a strobe: no event; `data_oe_x` returns to 1 `SYNC_STAGES`+1 cycles after the `slot_x` pin rises.

## Test plan
- Reset, then read addr 0 (address event with 00, read event) -> `data_out` = 68, `data_oe_x` = 0 during the data phase. After reset release, all outputs match their reset values for at least 10 cycles.
- Address 04, then write AA, 55, 3C with auto-inc on -> reads from addr 04 return AA, 55, 3C, and `ptr` ends at 07.
- With `NUM_REGS` = 16: address 0F, write 11, then write 22 -> reg15 = 11, and the second write lands in reg0, which is read-only, so reg0 still reads 68. Address 20, write 99 -> no register changes, read returns FF.
- Write ctrl = 0x80 -> `hd_sd_x` = `rgb_comp_x` = `int_ext_x` = 0, `video_oe_x` = 0. Write ctrl = 0x07 -> all four return to 1, and auto-inc is off, so the pointer holds on the next data event.
- Set mask = 01 and pulse `irq_src[0]` -> `int_x` = 0 two cycles later. Pulse `irq_src[1]` -> status = 03 and `int_x` stays 0. W1C 01 -> `int_x` = 1. Then W1C 02 issued in the same cycle as an `irq_src[1]` pulse -> status bit 1 remains 1.
- Assert `reset` between the address event and the data event -> `ptr` = 0 after reset, and the pending write does not occur.
